// File: rtl/vector_cmd_sequencer.sv
// rtl/vector_cmd_sequencer.sv - command FIFO and one-segment-at-a-time sequencer for the line rasteriser
module vector_cmd_sequencer #(
  parameter int DEPTH = 16,
  parameter int XMAX  = 639,
  parameter int YMAX  = 479
) (
  input  logic                     clk25,
  input  logic                     rst,
  input  logic                     cmd_valid,
  input  logic [15:0]              cmd_data,
  output logic                     cmd_ready,
  input  logic                     busy,
  output logic                     draw_enable,
  output logic [9:0]               x_from,
  output logic [9:0]               y_from,
  output logic [9:0]               x_to,
  output logic [9:0]               y_to,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     idle,
  output logic [15:0]              seg_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [9:0]    XMAX_C   = 10'(XMAX);
  localparam logic [9:0]    YMAX_C   = 10'(YMAX);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_ISSUE, ST_WAIT_START, ST_WAIT_DONE
  } state_t;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  state_t        state_q, state_d;
  logic [9:0]    cur_x_q, cur_x_d, cur_y_q, cur_y_d, pend_x_q, pend_x_d;
  logic [9:0]    x_from_q, x_from_d, y_from_q, y_from_d;
  logic [9:0]    x_to_q, x_to_d, y_to_q, y_to_d;
  logic [15:0]   seg_count_q, seg_count_d;
  logic          push, pop;
  logic [15:0]   word;
  logic [9:0]    ty;

  function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign cmd_ready  = (level_q != LVL_FULL);
  assign fifo_level = level_q;
  assign idle       = (level_q == '0) && (state_q == ST_IDLE) && !busy;
  assign x_from     = x_from_q;
  assign y_from     = y_from_q;
  assign x_to       = x_to_q;
  assign y_to       = y_to_q;
  assign seg_count  = seg_count_q;

  // FIFO bookkeeping, command decode and the segment handshake state machine
  always_comb begin
    push        = cmd_valid && cmd_ready;
    pop         = (state_q == ST_FETCH) && (level_q != '0);
    word        = mem_q[rd_ptr_q];
    ty          = clamp(word[9:0], YMAX_C);
    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d     = level_q;
    state_d     = state_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    pend_x_d    = pend_x_q;
    x_from_d    = x_from_q;
    y_from_d    = y_from_q;
    x_to_d      = x_to_q;
    y_to_d      = y_to_q;
    seg_count_d = seg_count_q;
    draw_enable = 1'b0;

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (level_q != '0) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_IDLE;
        if (pop) begin
          case (word[15:14])
            2'b01: pend_x_d = clamp(word[9:0], XMAX_C);
            2'b10: begin
              cur_x_d = pend_x_q;
              cur_y_d = ty;
              if (word[12]) begin
                x_from_d = cur_x_q;
                y_from_d = cur_y_q;
                x_to_d   = pend_x_q;
                y_to_d   = ty;
                state_d  = ST_ISSUE;
              end
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        // A rasteriser already busy (possibly for another source) holds us here.
        if (!busy) begin
          draw_enable = 1'b1;
          seg_count_d = seg_count_q + 16'd1;
          state_d     = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        // busy is still low in the cycle after the pulse; only its rise means "started".
        if (busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers are cleared
  always_ff @(posedge clk25) begin
    if (push) mem_q[wr_ptr_q] <= cmd_data;
  end

  // state and datapath registers
  always_ff @(posedge clk25) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= ST_IDLE;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      pend_x_q    <= '0;
      x_from_q    <= '0;
      y_from_q    <= '0;
      x_to_q      <= '0;
      y_to_q      <= '0;
      seg_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      pend_x_q    <= pend_x_d;
      x_from_q    <= x_from_d;
      y_from_q    <= y_from_d;
      x_to_q      <= x_to_d;
      y_to_q      <= y_to_d;
      seg_count_q <= seg_count_d;
    end
  end

endmodule

// File: doc/vector_cmd_sequencer.md
Name: vector_cmd_sequencer

Overview:
- Upstream stage of the line rasteriser in the HP1349A display path.
- Accepts a stream of 16-bit vector commands (set X, set Y with pen state) from the bus-capture logic and buffers them in a small FIFO.
- Tracks the current beam position and issues one line segment at a time to the rasteriser via its draw_enable/busy handshake.
- Pen-up moves update the beam position only; no segment is issued.

Parameters:
- DEPTH, 16, command FIFO depth in words; power of two, minimum 2.
- XMAX, 639, largest legal X coordinate; larger values are clamped.
- YMAX, 479, largest legal Y coordinate; larger values are clamped.

Ports:
- clk25  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command word present on cmd_data.
- cmd_data  in  16  command word; see Behaviour.
- cmd_ready  out  1  FIFO not full; a word is accepted when cmd_valid & cmd_ready.
- busy  in  1  rasteriser busy; high while a segment is being drawn.
- draw_enable  out  1  one-cycle start pulse to the rasteriser.
- x_from  out  10  segment start X.
- y_from  out  10  segment start Y.
- x_to  out  10  segment end X.
- y_to  out  10  segment end Y.
- fifo_level  out  $clog2(DEPTH)+1  number of words held in the FIFO.
- idle  out  1  FIFO empty, state IDLE, and busy low.
- seg_count  out  16  segments issued since reset; wraps at 65535->0.

Behaviour:
- Interface: one clock (clk25); reset rst is synchronous and active-high.
- Reset values: draw_enable=0; x_from/y_from/x_to/y_to=0; fifo_level=0; seg_count=0; state=IDLE; cur_x/cur_y=0; pend_x=0. cmd_ready=1 in the cycle after reset deasserts.

Command format:
- op = cmd_data[15:14].
- 00 NOP: consumed, no effect.
- 01 SET_X: pend_x <= clamp(cmd_data[9:0], XMAX).
- 10 SET_Y: ty = clamp(cmd_data[9:0], YMAX); pen = cmd_data[12].
  - pen=1: issue a segment from (cur_x,cur_y) to (pend_x,ty), then cur <= (pend_x,ty).
  - pen=0: cur <= (pend_x,ty) only.
- 11 reserved: consumed, ignored.
- Clamp rule: value > MAX gives MAX; otherwise unchanged.

FIFO:
- Synchronous, first-word-fall-through not required.
- Write and read in the same cycle are both honoured; level is unchanged.
- Write when full is blocked by cmd_ready=0; no overwrite.
- Read happens only in FETCH when not empty.
- Pointers wrap modulo DEPTH.

State machine:
- IDLE -> FETCH when FIFO not empty.
- FETCH: pop one word and decode it.
  - NOP, reserved, SET_X, or pen-up SET_Y -> IDLE. These updates complete in one cycle, so back-to-back commands sustain one word per 2 cycles.
  - Pen-down SET_Y: load x_from/y_from/x_to/y_to -> ISSUE.
- ISSUE: wait until busy=0, then drive draw_enable=1 for exactly that cycle, with coordinates stable -> WAIT_START. seg_count increments in the same cycle.
- WAIT_START: the rasteriser raises busy one cycle after the pulse. The sequencer waits for busy=1 (it must not treat busy=0 in the pulse+1 cycle as done) -> WAIT_DONE.
- WAIT_DONE: wait for busy=0 -> IDLE.
- cur_x/cur_y update in FETCH, so later SET_X words may be decoded only after the segment completes.

Coordinate outputs:
- Hold their last issued values outside ISSUE; they change only in FETCH.
- Zero-length segments (from == to) are issued normally and produce a single pixel.

Reset mid-operation:
- rst in any state empties the FIFO, returns to IDLE, and clears position registers and seg_count.
- draw_enable=0 in the cycle after rst is sampled.

Simultaneous events:
- A push in the same cycle as a FETCH pop is honoured.
- busy already high on entry to ISSUE (rasteriser occupied by another source) holds ISSUE; no pulse is issued.

Test Plan:
- Reset, then push 0x4064 (SET_X 100) and 0x9032 (SET_Y 50, pen down) -> one draw_enable pulse with from (0,0), to (100,50); seg_count=1.
- Pen-up positioning: push 0x400A, 0x8014 (pen up), 0x401E, 0x9028 -> only one pulse, from (10,20) to (30,40).
- Clamp: push SET_X 0x3FF and SET_Y pen-down 0x3FF -> x_to=639, y_to=479.
- Handshake model: busy rises 1 cycle after the pulse and stays high 20 cycles; queue 3 pen-down segments -> pulses never overlap busy; each next pulse comes ≥1 cycle after busy falls; no pulse in the pulse+1 gap.
- Full FIFO: hold busy=1 and push DEPTH+3 words -> cmd_ready=0 after fifo_level=DEPTH; no words lost or overwritten; draining restores the expected order.
- Reset mid-draw: assert rst while in WAIT_DONE with 5 words queued -> next cycle fifo_level=0, idle follows busy, draw_enable=0, seg_count=0.
